apb_completer_regfile: RTL
==========================

Name: apb_completer_regfile

Overview:
- APB4/APB5 completer that terminates the bus driven by the team's APB requester.
- Decodes PADDR into a word-addressed register array and performs byte-strobed writes and snapshot reads.
- Inserts a configurable number of wait states and returns PSLVERR on decode or protocol errors.
- Acts as the reference target on the APB dynamic verification environment.

Parameters:
- DEPTH, 16, number of 32-bit registers; power of two, minimum 2.
- BASE_ADDR, 32'h0000_0000, byte address of register 0; aligned to DEPTH*4.
- WAIT_STATES, 0, access-phase wait cycles per transfer, 0..15.
- CNT_W, 4, wait counter width; localparam, not overridable.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- PSELx  in  1  completer select.
- PENABLE  in  1  access phase indicator.
- PADDR  in  32  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  write data.
- PSTRB  in  4  write byte strobes; ignored on reads.
- PPROT  in  3  protection attributes.
- PNSE  in  1  APB5 non-secure extension.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response, valid only with PREADY.

Behaviour:
- Interface: one clock, PCLK. Reset PRESET is asynchronous and active-high.
- Reset: state goes to IDLE, counter to 0, all registers to 0. PRDATA=0, PREADY=0, PSLVERR=0.
- Reset asserted mid-transfer aborts the transfer immediately; no write occurs.
- States: IDLE, ACCESS.
- IDLE, on PSELx=1 and PENABLE=0 (setup phase):
  - Capture addr, PWRITE, PWDATA, PSTRB.
  - Compute err = (PADDR < BASE_ADDR) | (PADDR >= BASE_ADDR+4*DEPTH) | (PADDR[1:0] != 0).
  - Snapshot rdata_q = reg[(PADDR-BASE_ADDR)>>2], or 0 if err.
  - Load cnt = WAIT_STATES; go to ACCESS.
- ACCESS:
  - PREADY = (cnt == 0), combinational from registered state.
  - While PSELx & PENABLE & cnt != 0: cnt decrements each cycle.
  - Completion cycle is PSELx & PENABLE & PREADY.
    - Write with no error: reg[idx] byte lane i updated where PSTRB[i]=1, on that edge.
    - Always go to IDLE after completion.
  - PSELx=0 in ACCESS (requester abort): go to IDLE, no write, no response.
- Latency: setup + (WAIT_STATES+1) access cycles; a zero-wait transfer takes 2 cycles.
- Back-to-back transfers: a new setup phase follows completion directly; IDLE accepts it on the next cycle.
- PRDATA = rdata_q only in a read completion cycle; otherwise 0.
- PSLVERR = err only in a completion cycle; otherwise 0. An errored read returns PRDATA=0.
- Write with PSTRB=4'b0000: no change, OKAY response.
- Protocol violation (PSELx & PENABLE while in IDLE): PREADY=1 and PSLVERR=1 in the same cycle, no side effects.
- Read and write of the same register in adjacent transfers: the read sees the written value, because the snapshot is taken after the write edge.

Optional Feature:
- Macro: APB_PROT_CHECK_EN.
- Defined:
  - Registers with idx >= DEPTH/2 are secure.
  - Any access to them with PPROT[1]=1 (non-secure) or PNSE=1 sets err at setup.
  - Response is PSLVERR, no write, PRDATA=0.
- Undefined: PPROT and PNSE are ignored entirely.

Decomposition:
- Package apb_completer_pkg:
  - state enum {IDLE, ACCESS};
  - APB_OKAY/APB_SLVERR constants;
  - addr_decode function returning {err, idx}, including the prot check under the macro.
- Sub-module apb_regfile_strb: DEPTH x 32 array, async reset, byte-strobed write port, combinational read port.
- Top module: FSM, wait counter, response muxing.

Test Plan:
- Zero-wait write then read:
  - Stimulus: WAIT_STATES=0; write PADDR=0x8, PWDATA=0xDEADBEEF, PSTRB=4'hF; then read 0x8.
  - Response: PREADY=1 in the 2nd cycle of each transfer; PRDATA=0xDEADBEEF; PSLVERR=0.
- Byte strobes:
  - Stimulus: write 0x4 with 0x11223344/4'hF; then 0xAABBCCDD/4'b0101; then read 0x4.
  - Response: read returns 0x11BB33DD.
- Wait states and abort:
  - Stimulus: WAIT_STATES=3; read, counting access cycles.
  - Response: PREADY low for 3 access cycles, high on the 4th.
  - Stimulus: deassert PSELx after 1 wait cycle.
  - Response: FSM returns to IDLE, no PREADY, register unchanged.
- Decode errors:
  - Stimulus: DEPTH=16; write 0x40 (out of range); write 0x6 (misaligned).
  - Response: PSLVERR=1 with PREADY, no register changes, reads of these addresses return PRDATA=0.
- Reset and violation:
  - Stimulus: assert PRESET mid-write with wait states.
  - Response: outputs go to 0 immediately, all registers read back 0.
  - Stimulus: drive PSELx=1, PENABLE=1 from IDLE.
  - Response: PREADY=1 and PSLVERR=1 in the same cycle.
- Prot check (APB_PROT_CHECK_EN defined, DEPTH=16):
  - Stimulus: write 0x20 with PPROT=3'b010.
  - Response: PSLVERR=1.
  - Stimulus: same write with PPROT=3'b000.
  - Response: OKAY, register updated.
  - Stimulus: same cases with the macro undefined.
  - Response: both transfers OKAY.

Source files
------------

// File: rtl/apb_completer_regfile_pkg.sv
// Shared types and address decode for the APB register-file completer.
// APB_PROT_CHECK_EN: upper half of the array is secure-only.
package apb_completer_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic APB_OKAY   = 1'b0;
  localparam logic APB_SLVERR = 1'b1;

  typedef struct packed {
    logic        err;
    logic [31:0] idx;
  } decode_t;

  function automatic decode_t addr_decode(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] depth,
    input logic [2:0]  prot,
    input logic        nse
  );
    decode_t     d;
    logic [31:0] off;
    logic        unused_prot;
    off   = addr - base;
    d.idx = off >> 2;
    // Offset compare avoids overflow of base + 4*depth.
    d.err = (addr < base)
          | (off >= (depth << 2))
          | (addr[1:0] != 2'b00);
`ifdef APB_PROT_CHECK_EN
    if ((d.idx >= (depth >> 1)) && (prot[1] | nse))
      d.err = 1'b1;
    unused_prot = ^{prot[2], prot[0]};
`else
    unused_prot = ^{prot, nse};
`endif
    return d;
  endfunction

endpackage

// File: rtl/apb_completer_regfile_if.sv
// APB4/APB5 bus bundle between requester (master) and completer (slave).
// Carries select/enable/address/data/strobe/prot requests and the response.
interface apb_completer_regfile_if;
  logic        PSELx;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PNSE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSELx, PENABLE, PADDR, PWRITE,
    output PWDATA, PSTRB, PPROT, PNSE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PADDR, PWRITE,
    input  PWDATA, PSTRB, PPROT, PNSE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_completer_regfile_strb.sv
// DEPTH x 32 register array: async reset, byte-strobed write, comb read.
// Ports: clk, rst, we/widx/wdata/wstrb write port, ridx/rdata read port.
module apb_regfile_strb
  import apb_completer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b])
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer over a word-addressed register file with wait states.
// Ports: PCLK, PRESET (async, high), bus (slave modport). Macro APB_PROT_CHECK_EN.
module apb_completer_regfile
  import apb_completer_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  apb_completer_regfile_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [0:0]  ST_IDLE   = IDLE;
  localparam logic [0:0]  ST_ACCESS = ACCESS;
  localparam logic [CNT_W-1:0] CNT_LD =
    CNT_W'(WAIT_STATES);

  logic [0:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             write_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       strb_q;
  logic [31:0]      rdata_q;
  logic [31:0]      rd_word;

  decode_t          dec;
  logic [IDX_W-1:0] dec_idx;
  logic             unused_dec;

  logic setup;
  logic access;
  logic ready;
  logic complete;
  logic violation;
  logic we;

  assign dec = addr_decode(bus.PADDR, BASE_ADDR,
                           32'(DEPTH), bus.PPROT,
                           bus.PNSE);
  assign dec_idx    = dec.idx[IDX_W-1:0];
  assign unused_dec = ^dec.idx[31:IDX_W];

  assign setup  = (state_q == ST_IDLE)
                & bus.PSELx & ~bus.PENABLE;
  assign access = (state_q == ST_ACCESS)
                & bus.PSELx & bus.PENABLE;
  assign ready  = (state_q == ST_ACCESS)
                & (cnt_q == '0);
  assign complete = access & ready;
  // Access phase with no preceding setup: answer at once, touch nothing.
  assign violation = ~PRESET & (state_q == ST_IDLE)
                   & bus.PSELx & bus.PENABLE;
  assign we = complete & write_q & ~err_q;

  assign bus.PREADY  = ready | violation;
  assign bus.PSLVERR = complete ? err_q :
                       (violation ? APB_SLVERR : APB_OKAY);
  assign bus.PRDATA  = (complete & ~write_q) ?
                       rdata_q : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (setup) begin
        state_q <= ST_ACCESS;
        cnt_q   <= CNT_LD;
        err_q   <= dec.err;
        write_q <= bus.PWRITE;
        idx_q   <= dec_idx;
        wdata_q <= bus.PWDATA;
        strb_q  <= bus.PSTRB;
        // Snapshot sees any write committed on the previous edge.
        rdata_q <= dec.err ? '0 : rd_word;
      end
    end else begin
      if (!bus.PSELx || complete)
        state_q <= ST_IDLE;
      else if (access)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  apb_regfile_strb #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_rf (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .ridx  (dec_idx),
    .rdata (rd_word)
  );

endmodule
